ultrasonic_ctrl: RTL and testbench

Controller for an HC-SR04 style ultrasonic ranger, and the direct consumer of the 1 us tick from the frequency generator.
- On a start request it drives a trigger pulse, then waits for the echo and times its high width in microseconds.
- It converts the width to centimetres using no divider: one cm is added per US_PER_CM microseconds.
- It reports the result to downstream display/UART logic with done/error strobes.

---
 rtl/ultrasonic_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ultrasonic_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ctrl.sv
// HC-SR04 ranger controller: trigger pulse, echo timing in 1 us ticks, cm conversion without a divider.
// Result/strobe one clk after the synchronised echo fall (echo path adds 3 clks); no backpressure, start accepted only when idle.
module ultrasonic_ctrl #(
    parameter int TRIG_US      = 10,
    parameter int ECHO_WAIT_US = 30000,
    parameter int ECHO_MAX_US  = 25000,
    parameter int US_PER_CM    = 58
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1us,
    input  logic       start,
    input  logic       echo,
    output logic       trigger,
    output logic [8:0] distance,
    output logic       done,
    output logic       error,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRIG      = 2'd1,
        WAIT_ECHO = 2'd2,
        MEASURE   = 2'd3
    } state_t;

    // A limit is "reached" on the tick that would take the counter up to it.
    localparam logic [14:0] TRIG_LAST = 15'(TRIG_US - 1);
    localparam logic [14:0] WAIT_LAST = 15'(ECHO_WAIT_US - 1);
    localparam logic [14:0] MAX_LAST  = 15'(ECHO_MAX_US - 1);
    localparam logic [5:0]  SUB_LAST  = 6'(US_PER_CM - 1);

    state_t      state;
    state_t      state_nxt;
    logic        echo_m;
    logic        echo_s;
    logic        echo_d;
    logic        echo_rise;
    logic        echo_fall;
    logic [14:0] us_cnt;
    logic [5:0]  sub_cnt;
    logic [8:0]  cm_cnt;
    logic        trig_hit;
    logic        wait_hit;
    logic        max_hit;
    logic        meas_done;
    logic        meas_err;
    logic        wait_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

    assign trig_hit = tick_1us && (us_cnt == TRIG_LAST);
    assign wait_hit = tick_1us && (us_cnt == WAIT_LAST);
    assign max_hit  = tick_1us && (us_cnt == MAX_LAST);

    // A falling edge beats a simultaneous echo-max timeout.
    assign meas_done = (state == MEASURE) && echo_fall;
    assign meas_err  = (state == MEASURE) && !echo_fall && echo_s && max_hit;
    assign wait_err  = (state == WAIT_ECHO) && !echo_rise && wait_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                if (trig_hit) begin
                    state_nxt = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_nxt = MEASURE;
                end else if (wait_hit) begin
                    state_nxt = IDLE;
                end
            end
            MEASURE: begin
                if (meas_done || meas_err) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        trigger = (state == TRIG);
        busy    = (state != IDLE);
    end

    // One counter serves every phase; it restarts whenever the state changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_cnt <= '0;
        end else if (state_nxt != state) begin
            us_cnt <= '0;
        end else if (tick_1us && (state != IDLE)) begin
            us_cnt <= us_cnt + 15'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if ((state == WAIT_ECHO) && echo_rise) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if ((state == MEASURE) && tick_1us && echo_s) begin
            if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                cm_cnt  <= cm_cnt + 9'd1;
            end else begin
                sub_cnt <= sub_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            distance <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= meas_done;
            error <= wait_err | meas_err;
            if (meas_done) begin
                distance <= cm_cnt;
            end
        end
    end

    a_done_error_exclusive : assert property (@(posedge clk) disable iff (rst) !(done && error));
    a_distance_with_done   : assert property (@(posedge clk) disable iff (rst) (distance != $past(distance)) |-> done);

endmodule

// File: tb/tb_ultrasonic_ctrl.sv
// Bench for ultrasonic_ctrl: directed and random measurements against a tick-timestamp reference model.
module tb_ultrasonic_ctrl;

    localparam int P       = 4;
    localparam int TRIG_US = 10;
    localparam int WAIT_US = 600;
    localparam int MAX_US  = 1500;
    localparam int CM      = 58;
    localparam int M_IDLE  = 0;
    localparam int M_TRIG  = 1;
    localparam int M_WAIT  = 2;
    localparam int M_MEAS  = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tick_1us = 1'b0;
    logic       start    = 1'b0;
    logic       echo     = 1'b0;
    logic       trigger;
    logic       done;
    logic       error;
    logic       busy;
    logic [8:0] distance;

    int n_chk      = 0;
    int n_fail     = 0;
    int tick_count = 0;
    int tick_ph    = 0;

    // reference model state: absolute tick timestamps and deadlines
    int          m_ph       = M_IDLE;
    int          m_ticks    = 0;
    int          m_deadline = 0;
    int          m_echo     = 0;
    int          m_dist     = 0;
    bit          m_done     = 1'b0;
    bit          m_err      = 1'b0;
    logic [3:0]  eh         = '0;
    logic        s_r, s_tk, s_st, s_e;
    logic [12:0] exp_v;

    ultrasonic_ctrl #(
        .TRIG_US     (TRIG_US),
        .ECHO_WAIT_US(WAIT_US),
        .ECHO_MAX_US (MAX_US),
        .US_PER_CM   (CM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_1us(tick_1us),
        .start   (start),
        .echo    (echo),
        .trigger (trigger),
        .distance(distance),
        .done    (done),
        .error   (error),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick_ph  = (tick_ph + 1) % P;
            tick_1us = (tick_ph == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (tick_1us) tick_count++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Echo seen by the design is the bench echo two clks late; edges compare against three clks late.
    initial begin
        forever begin
            @(posedge clk);
            s_r  = rst;
            s_tk = tick_1us;
            s_st = start;
            s_e  = echo;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (s_r) begin
                m_ph    = M_IDLE;
                m_dist  = 0;
                m_ticks = 0;
                eh      = '0;
            end else begin
                eh = {eh[2:0], s_e};
                if (s_tk) m_ticks++;
                case (m_ph)
                    M_IDLE: if (s_st) begin
                        m_ph = M_TRIG;
                        m_deadline = m_ticks + TRIG_US;
                    end
                    M_TRIG: if (m_ticks == m_deadline) begin
                        m_ph = M_WAIT;
                        m_deadline = m_ticks + WAIT_US;
                    end
                    M_WAIT: begin
                        if (eh[2] && !eh[3]) begin
                            m_ph = M_MEAS;
                            m_echo = 0;
                            m_deadline = m_ticks + MAX_US;
                        end else if (m_ticks == m_deadline) begin
                            m_err = 1'b1;
                            m_ph  = M_IDLE;
                        end
                    end
                    M_MEAS: begin
                        if (!eh[2] && eh[3]) begin
                            m_done = 1'b1;
                            m_dist = m_echo / CM;
                            m_ph   = M_IDLE;
                        end else begin
                            if (s_tk && eh[2]) m_echo++;
                            if (m_ticks == m_deadline) begin
                                m_err = 1'b1;
                                m_ph  = M_IDLE;
                            end
                        end
                    end
                    default: m_ph = M_IDLE;
                endcase
            end
            exp_v = {m_ph == M_TRIG, m_ph != M_IDLE, m_done, m_err, 9'(m_dist)};
            #1;
            chk("cycle{trig,busy,done,err,dist}", 32'({trigger, busy, done, error, distance}), 32'(exp_v));
        end
    end

    function automatic bit hit(input int sel);
        case (sel)
            0:       return done === 1'b1;
            1:       return error === 1'b1;
            2:       return trigger === 1'b1;
            3:       return trigger !== 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int bound, output int n);
        n = 0;
        while (!hit(sel) && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic trig_phase();
        int n;
        int w;
        wait_for(2, 4, n);
        chk_range("trig_rise_delay", n, 0, 1);
        wait_for(3, 20 * P, w);
        chk_range("trig_width_clks", w, (TRIG_US - 1) * P + 1, TRIG_US * P);
    endtask

    task automatic measure(input int gap, input int eus, input bit pre, input int lo, input int hi);
        int n;
        if (pre) echo = 1'b1;
        start_pulse();
        chk("busy_after_start", 32'(busy), 32'(1));
        trig_phase();
        if (pre) begin
            clks(gap * P / 2);
            echo = 1'b0;
            clks(gap * P - gap * P / 2);
        end else begin
            clks(gap * P);
        end
        echo = 1'b1;
        clks(eus * P);
        echo = 1'b0;
        wait_for(0, 8, n);
        chk_range("done_latency_clks", n, 1, 4);
        chk_range("distance_cm", int'(distance), lo, hi);
        chk_range("model_distance_cm", m_dist, lo, hi);
        chk("busy_after_done", 32'(busy), 32'(0));
        clks(5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tc0;
        int trig_hi;
        int gap;
        int eus;
        bit pre;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({trigger, busy, done, error, distance}), 32'(0));
        rst = 1'b0;
        clks(1000);
        chk("idle_no_start", 32'({trigger, busy, done, error, distance}), 32'(0));

        measure(200, 600, 1'b0, 10, 10);
        measure(200, 1180, 1'b0, 20, 20);

        // echo never rises
        start_pulse();
        trig_phase();
        tc0 = tick_count;
        wait_for(1, (WAIT_US + 20) * P, n);
        chk_range("wait_timeout_ticks", tick_count - tc0, WAIT_US - 1, WAIT_US + 1);
        chk("dist_after_wait_timeout", 32'(distance), 32'(20));
        chk("busy_after_wait_timeout", 32'({busy, done}), 32'(0));
        clks(5);

        // echo stuck high
        start_pulse();
        trig_phase();
        clks(100 * P);
        echo = 1'b1;
        tc0 = tick_count;
        wait_for(1, (MAX_US + 20) * P, n);
        chk_range("echo_max_timeout_ticks", tick_count - tc0, MAX_US - 1, MAX_US + 1);
        chk("dist_after_max_timeout", 32'(distance), 32'(20));
        clks(100 * P);
        echo = 1'b0;
        clks(10);
        chk("idle_after_late_fall", 32'({busy, done}), 32'(0));

        measure(150, 50, 1'b0, 0, 0);

        // start held high through a measurement
        start = 1'b1;
        trig_phase();
        clks(100 * P);
        echo = 1'b1;
        trig_hi = 0;
        repeat (300 * P) begin
            @(negedge clk);
            if (trigger) trig_hi++;
        end
        echo = 1'b0;
        chk("no_retrigger_in_measure", 32'(trig_hi), 32'(0));
        wait_for(0, 8, n);
        chk_range("held_done_latency", n, 1, 4);
        chk("held_distance", 32'(distance), 32'(5));
        @(negedge clk);
        chk("rearm_trigger", 32'(trigger), 32'(1));
        start = 1'b0;
        wait_for(1, (WAIT_US + TRIG_US + 20) * P, n);
        chk("rearm_wait_timeout", 32'(error), 32'(1));
        clks(5);

        // asynchronous reset in the middle of an echo
        start_pulse();
        trig_phase();
        clks(50 * P);
        echo = 1'b1;
        clks(100 * P);
        rst = 1'b1;
        #1;
        chk("rst_async{trig,busy,dist}", 32'({trigger, busy, distance}), 32'(0));
        @(negedge clk);
        echo = 1'b0;
        clks(4);
        rst = 1'b0;
        clks(20);
        measure(100, 300, 1'b0, 5, 5);

        repeat (3) begin
            gap = int'($urandom_range(20, 400));
            eus = int'($urandom_range(30, 1000));
            pre = 1'($urandom_range(0, 1));
            measure(gap, eus, pre, (eus - 1) / CM, (eus + 1) / CM);
        end

        clks(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
